// File: rtl/mcyc_ctrl.sv
// Multi-cycle MIPS control unit: state register, memory-wait timeout, sticky overflow, decoded controls.
// Optional shift decode (sll/srl/sra) is enabled by defining CTRL_SHIFT_EN.
module mcyc_ctrl #(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Inst_in,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               CPU_MIO,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALU_operation,
  output logic [4:0]         state_out,
  output logic               err,
  output logic               ovf_flag
);

  typedef enum logic [4:0] {
    S_IF     = 5'd0,
    S_ID     = 5'd1,
    S_EX_R   = 5'd2,
    S_EX_MEM = 5'd3,
    S_EX_I   = 5'd4,
    S_LUI_WB = 5'd5,
    S_EX_BEQ = 5'd6,
    S_EX_BNE = 5'd7,
    S_EX_JR  = 5'd8,
    S_EX_JAL = 5'd9,
    S_EX_J   = 5'd10,
    S_MEM_RD = 5'd11,
    S_MEM_WD = 5'd12,
    S_WB_R   = 5'd13,
    S_WB_I   = 5'd14,
    S_WB_LW  = 5'd15,
    S_ERR    = 5'd31
  } state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_XOR  = 4'd3,
    OP_NOR  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLTU = 4'd10
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
`ifdef CTRL_SHIFT_EN
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
`endif

  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d, wait_inc;
  logic             ovf_q, ovf_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             timeout;

  logic [5:0] opcode, funct;
  assign opcode = Inst_in[31:26];
  assign funct  = Inst_in[5:0];

  // Only opcode and funct steer control; the ALU zero flag is consumed in the datapath.
  logic unused_bits;
  assign unused_bits = ^{zero, Inst_in[25:6]};

  alu_op_e r_op, i_op, alu_op;
  logic    r_valid;
  state_e  id_next;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    r_valid = 1'b1;
    r_op    = OP_ADD;
    case (funct)
      FN_ADD:  r_op = OP_ADD;
      FN_SUB:  r_op = OP_SUB;
      FN_AND:  r_op = OP_AND;
      FN_OR:   r_op = OP_OR;
      FN_XOR:  r_op = OP_XOR;
      FN_NOR:  r_op = OP_NOR;
      FN_SLT:  r_op = OP_SLT;
      FN_SLTU: r_op = OP_SLTU;
`ifdef CTRL_SHIFT_EN
      FN_SLL:  r_op = OP_SLL;
      FN_SRL:  r_op = OP_SRL;
      FN_SRA:  r_op = OP_SRA;
`endif
      default: r_valid = 1'b0;
    endcase
  end

  always_comb begin
    i_op = OP_ADD;
    case (opcode)
      OPC_ANDI: i_op = OP_AND;
      OPC_ORI:  i_op = OP_OR;
      OPC_XORI: i_op = OP_XOR;
      OPC_SLTI: i_op = OP_SLT;
      default:  i_op = OP_ADD;
    endcase
  end

  always_comb begin
    id_next = S_ERR;
    case (opcode)
      OPC_RTYPE:       id_next = (funct == FN_JR) ? S_EX_JR : S_EX_R;
      OPC_LW, OPC_SW:  id_next = S_EX_MEM;
      OPC_BEQ:         id_next = S_EX_BEQ;
      OPC_BNE:         id_next = S_EX_BNE;
      OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_SLTI:
                       id_next = S_EX_I;
      OPC_LUI:         id_next = S_LUI_WB;
      OPC_J:           id_next = S_EX_J;
      OPC_JAL:         id_next = S_EX_JAL;
      default:         id_next = S_ERR;
    endcase
  end

  // The wait count only survives while a memory-facing state keeps seeing MIO_ready=0.
  always_comb begin
    wait_inc = wait_q + CNT_W'(1);
    wait_d   = '0;
    timeout  = 1'b0;
    if ((state_q == S_IF || state_q == S_MEM_RD || state_q == S_MEM_WD) && !MIO_ready) begin
      wait_d  = wait_inc;
      timeout = (WAIT_MAX != 0) && (wait_inc == CNT_W'(WAIT_MAX));
    end
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = MIO_ready ? S_ID : (timeout ? S_ERR : S_IF);
      S_ID:     state_d = id_next;
      S_EX_MEM: state_d = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WD;
      S_EX_R:   state_d = r_valid ? S_WB_R : S_ERR;
      S_EX_I:   state_d = S_WB_I;
      S_MEM_RD: state_d = MIO_ready ? S_WB_LW : (timeout ? S_ERR : S_MEM_RD);
      S_MEM_WD: state_d = MIO_ready ? S_IF : (timeout ? S_ERR : S_MEM_WD);
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IF;
    endcase
  end

  // Overflow only matters for the signed add/sub forms; it is held for exactly the following WB.
  assign ovf_d = overflow &&
                 ((state_q == S_EX_R && (funct == FN_ADD || funct == FN_SUB)) ||
                  (state_q == S_EX_I && opcode == OPC_ADDI));
  assign ovf_flag_d = ovf_flag_q | ovf_d;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      wait_q     <= '0;
      ovf_q      <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      ovf_q      <= ovf_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    CPU_MIO     = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch      = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    alu_op      = OP_ADD;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
      end
      S_ID:     ALUSrcB = 2'b11;
      S_EX_R: begin
        ALUSrcA = 1'b1;
        alu_op  = r_op;
      end
      S_EX_MEM: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_EX_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_op  = i_op;
      end
      S_LUI_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      S_EX_BEQ, S_EX_BNE: begin
        ALUSrcA     = 1'b1;
        alu_op      = OP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Branch      = (state_q == S_EX_BEQ);
      end
      S_EX_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      S_EX_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
      end
      S_EX_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
      end
      S_MEM_WD: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        CPU_MIO  = 1'b1;
      end
      S_WB_R: begin
        RegWrite = ~ovf_q;
        RegDst   = 2'b01;
      end
      S_WB_I:   RegWrite = ~ovf_q;
      S_WB_LW: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      default: ;
    endcase
  end

  assign ALU_operation = ALUOP_W'(alu_op);
  assign state_out     = state_q;
  assign err           = (state_q == S_ERR);
  assign ovf_flag      = ovf_flag_q;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Self-checking bench for mcyc_ctrl: instruction-path model plus per-cycle compare and directed literal checks.
module tb_mcyc_ctrl;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Inst_in = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        MIO_ready = 1'b0;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [3:0]  ALU_operation;
  logic [4:0]  state_out;
  logic        err, ovf_flag;

  mcyc_ctrl #(.ALUOP_W(4), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
    .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation),
    .state_out(state_out), .err(err), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic       mem_read, mem_write, cpu_mio, iord, ir_write, reg_write, alu_src_a, pc_write, pc_write_cond, branch;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [7:0] alu_op;
    logic       err;
  } ctl_t;

  // Spec tables: R-type funct -> ALU op, I-type opcode -> ALU op.
  int r_ops[int];
  int i_ops[int];

  initial begin
    r_ops[6'h20] = 2; r_ops[6'h22] = 6; r_ops[6'h24] = 0; r_ops[6'h25] = 1;
    r_ops[6'h26] = 3; r_ops[6'h27] = 4; r_ops[6'h2A] = 7; r_ops[6'h2B] = 10;
`ifdef CTRL_SHIFT_EN
    r_ops[6'h00] = 8; r_ops[6'h02] = 5; r_ops[6'h03] = 9;
`endif
    i_ops[6'h08] = 2; i_ops[6'h0C] = 0; i_ops[6'h0D] = 1; i_ops[6'h0E] = 3; i_ops[6'h0A] = 7;
  end

  // Model: the whole state path of an instruction is planned at decode, then consumed one step per cycle.
  int   m_state = 0;
  int   m_wait = 0;
  bit   m_ovf = 0;
  bit   m_flag = 0;
  int   m_path[$];

  task automatic plan(input logic [31:0] ins);
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    case (op)
      6'h00:   if (fn == 6'h08) m_path = {8};
               else if (r_ops.exists(fn)) m_path = {2, 13};
               else m_path = {2, 31};
      6'h23:   m_path = {3, 11, 15};
      6'h2B:   m_path = {3, 12};
      6'h04:   m_path = {6};
      6'h05:   m_path = {7};
      6'h0F:   m_path = {5};
      6'h02:   m_path = {10};
      6'h03:   m_path = {9};
      default: if (i_ops.exists(op)) m_path = {4, 14}; else m_path = {31};
    endcase
  endtask

  function automatic int pop();
    if (m_path.size() == 0) return 0;
    return m_path.pop_front();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_wait = 0; m_ovf = 0; m_flag = 0;
      m_path.delete();
    end else begin
      m_ovf = overflow && ((m_state == 2 && (Inst_in[5:0] == 6'h20 || Inst_in[5:0] == 6'h22)) ||
                           (m_state == 4 && Inst_in[31:26] == 6'h08));
      if (m_ovf) m_flag = 1;
      if (m_state == 31) begin
      end else if (m_state == 0 || m_state == 11 || m_state == 12) begin
        if (MIO_ready) begin
          m_wait  = 0;
          m_state = (m_state == 0) ? 1 : pop();
        end else begin
          m_wait++;
          if (WAIT_MAX != 0 && m_wait == WAIT_MAX) m_state = 31;
        end
      end else if (m_state == 1) begin
        plan(Inst_in);
        m_state = pop();
      end else begin
        m_state = pop();
      end
    end
  end

  function automatic ctl_t exp_ctl(input int s, input logic [31:0] ins, input logic rdy, input bit ovf);
    ctl_t c;
    int   fn, op;
    fn = int'(ins[5:0]);
    op = int'(ins[31:26]);
    c = '0;
    c.alu_op = 8'd2;
    case (s)
      0:  begin c.mem_read = 1; c.cpu_mio = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; if (r_ops.exists(fn)) c.alu_op = 8'(r_ops[fn]); end
      3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; if (i_ops.exists(op)) c.alu_op = 8'(i_ops[op]); end
      5:  begin c.reg_write = 1; c.mem_to_reg = 2'b10; end
      6, 7: begin
        c.alu_src_a = 1; c.alu_op = 8'd6; c.pc_write_cond = 1; c.pc_source = 2'b01; c.branch = (s == 6);
      end
      8:  begin c.pc_write = 1; c.pc_source = 2'b11; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b11; end
      10: begin c.pc_write = 1; c.pc_source = 2'b10; end
      11: begin c.mem_read = 1; c.iord = 1; c.cpu_mio = 1; end
      12: begin c.mem_write = 1; c.iord = 1; c.cpu_mio = 1; end
      13: begin c.reg_write = !ovf; c.reg_dst = 2'b01; end
      14: c.reg_write = !ovf;
      15: begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      31: c.err = 1;
      default: ;
    endcase
    return c;
  endfunction

  always @(negedge clk) begin : compare
    ctl_t e_c, a_c;
    #2;
    e_c = exp_ctl(m_state, Inst_in, MIO_ready, m_ovf);
    a_c = '{mem_read: MemRead, mem_write: MemWrite, cpu_mio: CPU_MIO, iord: IorD, ir_write: IRWrite,
            reg_write: RegWrite, alu_src_a: ALUSrcA, pc_write: PCWrite, pc_write_cond: PCWriteCond,
            branch: Branch, reg_dst: RegDst, mem_to_reg: MemtoReg, alu_src_b: ALUSrcB,
            pc_source: PCSource, alu_op: 8'(ALU_operation), err: err};
    check("cyc_state", 32'(state_out), 32'(m_state));
    check("cyc_ctl", 32'(a_c), 32'(e_c));
    check("cyc_ovf_flag", 32'(ovf_flag), 32'(m_flag));
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic look(input string nm, input int exp_state);
    #3;
    check(nm, 32'(state_out), 32'(exp_state));
  endtask

  task automatic do_reset();
    nxt();
    reset = 1'b1;
    MIO_ready = 1'b1;
    overflow = 1'b0;
    nxt();
    reset = 1'b0;
    look("rst_state", 0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovf_flag", 32'(ovf_flag), 32'd0);
  endtask

  // Run one instruction from IF with memory always ready; overflow is held for the whole instruction.
  task automatic run(input logic [31:0] ins, input logic ov);
    Inst_in  = ins;
    overflow = ov;
    MIO_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nxt();
      #3;
      if (state_out == 5'd0) break;
    end
    check("run_back_to_if", 32'(state_out), 32'd0);
    overflow = 1'b0;
  endtask

  initial begin
    repeat (2) nxt();
    look("rst_state", 0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovf_flag", 32'(ovf_flag), 32'd0);

    // add: IF, ID, EX_R, WB_R, IF
    nxt(); reset = 1'b0; MIO_ready = 1'b1; Inst_in = 32'h0022_1820;
    look("add_s0", 0);
    nxt(); look("add_s1", 1);
    nxt(); look("add_s2", 2);
    check("add_aluop", 32'(ALU_operation), 32'd2);
    nxt(); look("add_s3", 13);
    check("add_regwrite", 32'(RegWrite), 32'd1);
    check("add_regdst", 32'(RegDst), 32'd1);
    nxt(); look("add_s4", 0);

    // lw with three not-ready cycles in MEM_RD
    Inst_in = 32'h8C22_0004;
    nxt(); look("lw_id", 1);
    nxt(); look("lw_exmem", 3);
    nxt(); MIO_ready = 1'b0; look("lw_mem1", 11);
    nxt(); look("lw_mem2", 11);
    nxt(); look("lw_mem3", 11);
    nxt(); MIO_ready = 1'b1; look("lw_mem4", 11);
    nxt(); look("lw_wb", 15);
    check("lw_regwrite", 32'(RegWrite), 32'd1);
    check("lw_memtoreg", 32'(MemtoReg), 32'd1);
    nxt(); look("lw_if", 0);

    // bne
    Inst_in = 32'h1422_0003;
    nxt(); look("bne_id", 1);
    nxt(); look("bne_ex", 7);
    check("bne_branch", 32'(Branch), 32'd0);
    check("bne_pcwc", 32'(PCWriteCond), 32'd1);
    check("bne_aluop", 32'(ALU_operation), 32'd6);
    nxt(); look("bne_if", 0);

    // sw interrupted by reset in MEM_WD
    Inst_in = 32'hAC22_0004;
    nxt(); look("sw_id", 1);
    nxt(); look("sw_exmem", 3);
    nxt(); look("sw_memwd", 12);
    #1 reset = 1'b1;
    #1 check("sw_async_rst", 32'(state_out), 32'd0);
    nxt(); reset = 1'b0; look("sw_after_rst", 0);

    // addi with overflow in EX_I
    Inst_in = 32'h2022_0005;
    nxt(); look("addi_id", 1);
    nxt(); overflow = 1'b1; look("addi_ex", 4);
    nxt(); overflow = 1'b0; look("addi_wb", 14);
    check("addi_ovf_regwrite", 32'(RegWrite), 32'd0);
    check("addi_ovf_flag", 32'(ovf_flag), 32'd1);
    nxt(); look("addi_if", 0);
    check("ovf_sticky", 32'(ovf_flag), 32'd1);

    // Remaining instruction classes, checked cycle by cycle against the model
    run(32'h0022_1820, 1'b1);  // add with overflow
    run(32'h0022_1824, 1'b1);  // and: overflow ignored
    run(32'h0022_1822, 1'b0);  // sub
    run(32'h0022_1825, 1'b0);  // or
    run(32'h0022_1826, 1'b0);  // xor
    run(32'h0022_1827, 1'b0);  // nor
    run(32'h0022_182A, 1'b0);  // slt
    run(32'h0022_182B, 1'b0);  // sltu
    run(32'h3022_0001, 1'b1);  // andi: overflow ignored
    run(32'h3422_0001, 1'b0);  // ori
    run(32'h3822_0001, 1'b0);  // xori
    run(32'h2822_0001, 1'b0);  // slti
    run(32'h1022_0003, 1'b0);  // beq
    run(32'h0800_0010, 1'b0);  // j
    run(32'h0C00_0010, 1'b0);  // jal
    run(32'h03E0_0008, 1'b0);  // jr
    run(32'h3C01_1234, 1'b0);  // lui
    run(32'hAC22_0004, 1'b0);  // sw

    // sll: legal only with the shift option
    Inst_in = 32'h0001_1080;
    nxt(); look("sll_id", 1);
    nxt(); look("sll_ex", 2);
`ifdef CTRL_SHIFT_EN
    check("sll_aluop", 32'(ALU_operation), 32'd8);
    nxt(); look("sll_wb", 13);
    nxt(); look("sll_if", 0);
`else
    nxt(); look("sll_err", 31);
    check("sll_err_flag", 32'(err), 32'd1);
`endif
    do_reset();

    // Undefined opcode 0x3F goes to ERR and stays there
    Inst_in = 32'hFC00_0000;
    nxt(); look("badop_id", 1);
    nxt(); look("badop_err", 31);
    check("badop_err_flag", 32'(err), 32'd1);
    nxt(); nxt(); look("badop_hold", 31);
    do_reset();

    // Memory never ready in IF: ERR after WAIT_MAX cycles
    nxt(); reset = 1'b1; MIO_ready = 1'b0;
    nxt(); reset = 1'b0;
    repeat (WAIT_MAX - 1) nxt();
    look("to_last_if", 0);
    nxt(); look("to_err", 31);
    check("to_err_flag", 32'(err), 32'd1);
    repeat (3) nxt();
    look("to_hold", 31);
    do_reset();

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 expected earlier end");
    $fatal(1);
  end

endmodule
